// File: rtl/btn_debounce_pulse.sv
// Push-button front end: synchroniser, stable-time debouncer and press/release pulse generator.
// Optional auto-repeat of press_pulse while held, enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYC      = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD_CYC = 5_000_000,
  parameter bit          ACTIVE_HIGH       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sync1_reg;
  logic             sync2_reg;
  logic             btn_pol;
  logic             btn_s;
  logic             level_reg;
  logic             press_reg;
  logic             release_reg;
  logic             repeat_reg;

  // Polarity is corrected before the synchroniser so the FSM always sees 1 = pressed.
  assign btn_pol = ACTIVE_HIGH ? btn_raw : ~btn_raw;
  assign btn_s   = sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_pol;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int unsigned RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYC - 1);

  logic [RPT_W-1:0] rpt_cnt_reg;
  logic             rpt_phase_reg;  // 0: waiting for first repeat, 1: periodic repeats
  logic             rpt_fire;

  assign rpt_fire = rpt_phase_reg ? (rpt_cnt_reg == RPT_PERIOD_LAST)
                                  : (rpt_cnt_reg == RPT_DELAY_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      level_reg     <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      repeat_reg    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_reg   <= '0;
      rpt_phase_reg <= 1'b0;
`endif
    end else begin
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
      // Stable-time counter saturates; every state change below clears it.
      if (cnt_reg != CNT_SAT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (btn_s) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!btn_s) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg     <= HELD;
            cnt_reg       <= '0;
            press_reg     <= 1'b1;
            level_reg     <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt_reg   <= '0;
            rpt_phase_reg <= 1'b0;
`endif
          end
        end

        HELD: begin
          if (!btn_s) begin
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rpt_fire) begin
            press_reg     <= 1'b1;
            repeat_reg    <= 1'b1;
            rpt_cnt_reg   <= '0;
            rpt_phase_reg <= 1'b1;
          end else begin
            rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
          end
`endif
        end

        RELEASE_WAIT: begin
          // A bounce back to pressed resumes HELD silently; the repeat counter keeps its value.
          if (btn_s) begin
            state_reg <= HELD;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            release_reg <= 1'b1;
            level_reg   <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign btn_level     = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign repeat_pulse  = repeat_reg;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_PERIOD_CYC=3).
// Expected latencies are counted in cycles: cyc=1 is the first edge that samples a new btn_raw value.
module tb_btn_debounce_pulse;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  int total = 0;
  int passed = 0;

  int cyc;
  int press_cnt;
  int release_cnt;
  int repeat_cnt;
  int first_press_at;
  int first_release_at;
  int first_repeat_at;
  int last_repeat_at;
  int overlap_cnt = 0;
  int orphan_rep_cnt = 0;

  btn_debounce_pulse #(
    .DEBOUNCE_CYC      (4),
    .REPEAT_DELAY_CYC  (10),
    .REPEAT_PERIOD_CYC (3),
    .ACTIVE_HIGH       (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic mark();
    cyc              = 0;
    press_cnt        = 0;
    release_cnt      = 0;
    repeat_cnt       = 0;
    first_press_at   = -1;
    first_release_at = -1;
    first_repeat_at  = -1;
    last_repeat_at   = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (press_pulse === 1'b1) begin
      press_cnt++;
      if (first_press_at < 0) first_press_at = cyc;
    end
    if (release_pulse === 1'b1) begin
      release_cnt++;
      if (first_release_at < 0) first_release_at = cyc;
    end
    if (repeat_pulse === 1'b1) begin
      repeat_cnt++;
      if (first_repeat_at < 0) first_repeat_at = cyc;
      last_repeat_at = cyc;
      if (press_pulse !== 1'b1) orphan_rep_cnt++;
    end
    if (press_pulse === 1'b1 && release_pulse === 1'b1) overlap_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    mark();
    run(3);
    chk("rst_level",   btn_level,     0);
    chk("rst_press",   press_pulse,   0);
    chk("rst_release", release_pulse, 0);
    chk("rst_repeat",  repeat_pulse,  0);

    // Button held through reset release is a fresh press.
    rst_n = 1'b1;
    mark();
    run(10);
    chk("rst_rel_press_cnt", press_cnt, 1);
    chk("rst_rel_press_at",  first_press_at, 7);
    chk("rst_rel_level",     btn_level, 1);

    btn_raw = 1'b0;
    mark();
    run(10);
    chk("rel1_release_cnt", release_cnt, 1);
    chk("rel1_release_at",  first_release_at, 7);
    chk("rel1_level",       btn_level, 0);
    chk("rel1_press_cnt",   press_cnt, 0);

    // Clean press held 20 cycles.
    btn_raw = 1'b1;
    mark();
    run(20);
    chk("clean_press_at", first_press_at, 7);
`ifdef BTN_AUTOREPEAT_EN
    chk("clean_press_cnt", press_cnt, 3);
`else
    chk("clean_press_cnt", press_cnt, 1);
`endif
    chk("clean_level",   btn_level, 1);
    chk("clean_rel_cnt", release_cnt, 0);
    btn_raw = 1'b0;
    mark();
    run(10);
    chk("clean_release_at", first_release_at, 7);
    chk("clean_release_pr", press_cnt, 0);
    chk("clean_level0",     btn_level, 0);

    // Bounce 1,0,1,0 then stable 1 (stable high sampled at cyc 5).
    mark();
    btn_raw = 1'b1; step();
    btn_raw = 1'b0; step();
    btn_raw = 1'b1; step();
    btn_raw = 1'b0; step();
    btn_raw = 1'b1;
    run(10);
    chk("bounce_press_cnt", press_cnt, 1);
    chk("bounce_press_at",  first_press_at, 11);
    chk("bounce_level",     btn_level, 1);
    btn_raw = 1'b0;
    mark();
    run(10);
    chk("bounce_release_cnt", release_cnt, 1);
    chk("bounce_level0",      btn_level, 0);

    // Glitch of 3 cycles: one short of the debounce time.
    mark();
    btn_raw = 1'b1;
    run(3);
    btn_raw = 1'b0;
    run(10);
    chk("glitch_press_cnt", press_cnt, 0);
    chk("glitch_level",     btn_level, 0);

    // Release bounce from HELD.
    btn_raw = 1'b1;
    mark();
    run(10);
    chk("rb_press_cnt", press_cnt, 1);
    mark();
    btn_raw = 1'b0;
    run(2);
    btn_raw = 1'b1;
    run(6);
    chk("rb_release_cnt", release_cnt, 0);
    chk("rb_level",       btn_level, 1);
    btn_raw = 1'b0;
    mark();
    run(10);
    chk("rb_release_at",  first_release_at, 7);
    chk("rb_release_cnt2", release_cnt, 1);
    chk("rb_level0",      btn_level, 0);

    // Reset while held: asynchronous clear, then a new press after release of reset.
    btn_raw = 1'b1;
    mark();
    run(8);
    chk("mid_level_before", btn_level, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_level_async", btn_level, 0);
    chk("mid_press_async", press_pulse, 0);
    run(2);
    rst_n = 1'b1;
    mark();
    run(10);
    chk("mid_press_cnt", press_cnt, 1);
    chk("mid_press_at",  first_press_at, 7);
    btn_raw = 1'b0;
    mark();
    run(10);
    chk("mid_release_cnt", release_cnt, 1);

    // Long hold: auto-repeat at +10, +13 ... +28 after the first press pulse.
    btn_raw = 1'b1;
    mark();
    run(35);
    chk("ar_first_press_at", first_press_at, 7);
`ifdef BTN_AUTOREPEAT_EN
    chk("ar_press_cnt",  press_cnt, 8);
    chk("ar_repeat_cnt", repeat_cnt, 7);
    chk("ar_first_rep",  first_repeat_at, 17);
    chk("ar_last_rep",   last_repeat_at, 35);
`else
    chk("ar_press_cnt",  press_cnt, 1);
    chk("ar_repeat_cnt", repeat_cnt, 0);
`endif
    btn_raw = 1'b0;
    mark();
    run(12);
    chk("ar_stop_press",   press_cnt, 0);
    chk("ar_stop_repeat",  repeat_cnt, 0);
    chk("ar_release_cnt",  release_cnt, 1);
    chk("ar_level0",       btn_level, 0);

    chk("press_release_overlap", overlap_cnt, 0);
    chk("repeat_without_press",  orphan_rep_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
